core_seq_ctrl: RTL and testbench

CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

---
 rtl/core_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// Sequencer for the q/k attention core: loads q and k words, runs the kernel
// read and execute passes, drains the output FIFO into psum memory and reads it back.
//
// state   | meaning
// IDLE    | waiting for start; job size latched on accept
// QLOAD   | host writes q words into qmem, one per in_valid cycle
// KLOAD   | host writes k words into kmem, one per in_valid cycle
// KREAD   | stream kmem into the array's kernel registers
// QEXEC   | stream qmem through the array and execute
// DRAIN   | move completed psum rows from the FIFO into pmem
// READOUT | read pmem back out to the host
// DONE    | one-cycle completion pulse
module core_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int CW        = ADDR_W + 1;
  localparam int PS_LSB    = 8;
  localparam int QK_LSB    = 8 + ADDR_W;
  localparam int OFIFO_BIT = INST_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QLOAD,
    ST_KLOAD,
    ST_KREAD,
    ST_QEXEC,
    ST_DRAIN,
    ST_READOUT,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic              ov_q, ov_d;

  logic [INST_W-1:0] inst_c;
  logic              in_ready_c;
  logic              done_c;

  logic [CW-1:0]     last_idx;
  logic [CW-1:0]     last_p1;
  logic              in_range;

  assign last_idx = {1'b0, n_q};
  assign last_p1  = last_idx + CW'(1);
  assign in_range = (cnt_q <= last_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    ov_d       = 1'b0;
    inst_c     = '0;
    in_ready_c = 1'b0;
    done_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = num;
          cnt_d   = '0;
          state_d = ST_QLOAD;
        end
      end

      ST_QLOAD, ST_KLOAD: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          inst_c[QK_LSB +: ADDR_W] = cnt_q[ADDR_W-1:0];
          if (state_q == ST_QLOAD) inst_c[4] = 1'b1;
          else                     inst_c[2] = 1'b1;
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = (state_q == ST_QLOAD) ? ST_KLOAD : ST_KREAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Both streaming passes trail the SRAM read by one cycle, hence N+2 cycles.
      ST_KREAD, ST_QEXEC: begin
        if (in_range) begin
          inst_c[QK_LSB +: ADDR_W] = cnt_q[ADDR_W-1:0];
          if (state_q == ST_KREAD) inst_c[3] = 1'b1;
          else                     inst_c[5] = 1'b1;
        end
        if (cnt_q != '0) begin
          if (state_q == ST_KREAD) inst_c[6] = 1'b1;
          else                     inst_c[7] = 1'b1;
        end
        if (cnt_q == last_p1) begin
          cnt_d   = '0;
          state_d = (state_q == ST_KREAD) ? ST_QEXEC : ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DRAIN: begin
        if (fifo_valid) begin
          inst_c[OFIFO_BIT]        = 1'b1;
          inst_c[0]                = 1'b1;
          inst_c[PS_LSB +: ADDR_W] = cnt_q[ADDR_W-1:0];
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = ST_READOUT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_READOUT: begin
        if (in_range) begin
          inst_c[1]                = 1'b1;
          inst_c[PS_LSB +: ADDR_W] = cnt_q[ADDR_W-1:0];
          ov_d                     = 1'b1;
        end
        if (cnt_q == last_p1) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        done_c  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign inst      = inst_c;
  assign in_ready  = in_ready_c;
  assign done      = done_c;
  assign out_valid = ov_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: a job-level model queues the expected
// instruction/readout events and a negedge monitor pops and compares them.
module tb_core_seq_ctrl;

  localparam int AW = 4;
  localparam int IW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num = '0;
  logic          in_valid = 1'b0;
  logic          fifo_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] inst;
  logic          out_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  core_seq_ctrl #(.ADDR_W(AW), .INST_W(IW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num        (num),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fifo_valid (fifo_valid),
    .inst       (inst),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  typedef enum int {K_LOAD, K_DRAIN, K_FIX, K_EXEC, K_DONE} kind_e;
  typedef struct {
    kind_e         kind;
    logic [IW+1:0] word;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  lat_cnt = 0;
  int  exp_lat = -1;
  int  iv_mode = 1;   // 0 random, 1 held high, 2 held low
  int  fv_mode = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW+1:0] mk(int bits, int qk, int ps, bit ov, bit dn);
    logic [IW-1:0] w;
    w = IW'(bits) | IW'(qk << 12) | IW'(ps << 8);
    return {w, ov, dn};
  endfunction

  function automatic void push(kind_e k, logic [IW+1:0] w);
    ev_t e;
    e.kind = k;
    e.word = w;
    q.push_back(e);
  endfunction

  // Expected event stream of one job of n+1 vectors, in issue order.
  function automatic void push_job(int n);
    lat_cnt = 0;
    for (int i = 0; i <= n; i++) push(K_LOAD, mk(1 << 4, i, 0, 0, 0));
    for (int i = 0; i <= n; i++) push(K_LOAD, mk(1 << 2, i, 0, 0, 0));
    for (int i = 0; i <= n + 1; i++)
      push(K_FIX, mk(((i <= n) ? (1 << 3) : 0) | ((i >= 1) ? (1 << 6) : 0),
                     (i <= n) ? i : 0, 0, 0, 0));
    for (int i = 0; i <= n + 1; i++)
      push(K_EXEC, mk(((i <= n) ? (1 << 5) : 0) | ((i >= 1) ? (1 << 7) : 0),
                      (i <= n) ? i : 0, 0, 0, 0));
    for (int i = 0; i <= n; i++) push(K_DRAIN, mk((1 << 16) | 1, 0, i, 0, 0));
    for (int i = 0; i <= n + 1; i++)
      push(K_FIX, mk((i <= n) ? 2 : 0, 0, (i <= n) ? i : 0, i >= 1, 0));
    push(K_DONE, mk(0, 0, 0, 0, 1));
  endfunction

  always @(negedge clk) begin
    logic          exp_active;
    logic [IW+1:0] act;
    act = {inst, out_valid, done};
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != 0 && q[0].kind == K_LOAD));
    if (q.size() == 0) exp_active = 1'b0;
    else begin
      case (q[0].kind)
        K_LOAD:  exp_active = in_valid;
        K_DRAIN: exp_active = fifo_valid;
        default: exp_active = 1'b1;
      endcase
    end
    chk("activity", 32'(|act), 32'(exp_active));
    if (q.size() != 0) begin
      if (q[0].kind == K_DONE) begin
        if (exp_lat >= 0) chk("latency", lat_cnt, exp_lat);
      end else begin
        lat_cnt++;
      end
      if (exp_active) begin
        chk("event", 32'(act), 32'(q[0].word));
        void'(q.pop_front());
      end
    end
  end

  function automatic logic pick(int mode);
    if (mode == 0) return 1'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic drive_valids();
    in_valid   = pick(iv_mode);
    fifo_valid = pick(fv_mode);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_valids();
  endtask

  task automatic issue_start(int n);
    start = 1'b1;
    num   = AW'(n);
    @(posedge clk);
    push_job(n);
    #1;
    start = 1'b0;
    drive_valids();
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    if (q.size() != 0) begin
      chk("job_timeout", 32'(q.size()), 0);
      q.delete();
    end
  endtask

  task automatic wait_front(kind_e kd, int budget);
    int k = 0;
    while (!(q.size() != 0 && q[0].kind == kd) && k < budget) begin
      step();
      k++;
    end
    if (!(q.size() != 0 && q[0].kind == kd)) chk("phase_timeout", 32'(kd), 32'hffff);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_inst"}, 32'(inst), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d events pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // Full-rate job, start on the first edge after release.
    reset = 1'b1;
    iv_mode = 1; fv_mode = 1;
    exp_lat = 27;
    issue_start(3);
    wait_idle(200);

    exp_lat = 9;
    issue_start(0);
    wait_idle(100);

    // Sparse q writes: 1,0,1,0.
    exp_lat = -1;
    issue_start(1);
    in_valid = 1'b1; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; step();
    in_valid = 1'b0; step();
    wait_idle(200);

    // FIFO stall of 10 cycles mid-drain.
    issue_start(5);
    wait_front(K_DRAIN, 200);
    step();
    fv_mode = 2;
    repeat (10) step();
    fv_mode = 1;
    wait_idle(200);

    // Largest job with a stray start during execute.
    exp_lat = 99;
    issue_start(15);
    wait_front(K_EXEC, 200);
    start = 1'b1; num = AW'(3);
    step();
    start = 1'b0;
    wait_idle(300);

    // Start during the DONE cycle must be dropped.
    exp_lat = -1;
    iv_mode = 0; fv_mode = 0;
    issue_start(2);
    wait_front(K_DONE, 400);
    start = 1'b1; num = AW'(7);
    step();
    start = 1'b0;
    wait_idle(10);

    // Reset mid-drain, then a fresh job.
    issue_start(4);
    wait_front(K_DRAIN, 400);
    step();
    reset = 1'b0;
    q.delete();
    #1;
    check_all_zero("midrst");
    repeat (3) step();
    reset = 1'b1;
    iv_mode = 1; fv_mode = 1;
    exp_lat = 39;
    issue_start(5);
    wait_idle(200);

    exp_lat = -1;
    iv_mode = 0; fv_mode = 0;
    for (int j = 0; j < 12; j++) begin
      issue_start(int'($urandom_range(0, 15)));
      wait_idle(2000);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
